// File: rtl/custom_pkg.sv
// Shared constants and types for the integer register file and its busy scoreboard.
package custom_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy scoreboard: rsv_ok_o is combinational; the busy vector and count update on the edge.
// A refused reservation leaves the state untouched and the requester retries.
module reg_scoreboard
    import custom_pkg::*;
#(
    parameter int NREGS = custom_pkg::NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [NREGS-1:0] clr_i,
    input  logic             rsv_en_i,
    input  logic [AW-1:0]    rsv_addr_i,
    output logic [NREGS-1:0] busy_o,
    output logic             rsv_ok_o,
    output logic [AW:0]      busy_cnt_o
);

    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_cnt;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;
    logic             w_rsv_ok;

    // A write-clear in the same cycle frees the register for the new producer, and set wins.
    always_comb begin
        w_rsv_ok = rsv_en_i & ((rsv_addr_i == '0) | ~r_busy[rsv_addr_i] | clr_i[rsv_addr_i]);
        w_set    = '0;
        if (w_rsv_ok && (rsv_addr_i != '0)) begin
            w_set[rsv_addr_i] = 1'b1;
        end
        w_busy_nxt = (r_busy & ~clr_i) | w_set;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy_o     = r_busy;
    assign rsv_ok_o   = w_rsv_ok;
    assign busy_cnt_o = r_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with busy scoreboard; reads are combinational, writes land on the edge.
// REG_FILE_BYPASS_EN forwards same-cycle writeback data to matching read ports; no backpressure beyond rsv_ok_o.
module reg_file_sb
#(
    parameter int XLEN  = custom_pkg::XLEN,
    parameter int NREGS = custom_pkg::NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr_i,
    output logic [NRD*XLEN-1:0]         rd_data_o,
    output logic [NRD-1:0]              rd_busy_o,
    input  logic [NWR-1:0]              wr_en_i,
    input  logic [NWR*$clog2(NREGS)-1:0] wr_addr_i,
    input  logic [NWR*XLEN-1:0]         wr_data_i,
    input  logic                        rsv_en_i,
    input  logic [$clog2(NREGS)-1:0]    rsv_addr_i,
    output logic                        rsv_ok_o,
    output logic [$clog2(NREGS):0]      busy_cnt_o
);

    import custom_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_busy;
    logic             w_rsv_ok;
    logic [AW-1:0]    w_ra   [NRD];
    logic [XLEN-1:0]  w_rd   [NRD];
    logic [NRD-1:0]   w_rb;

    always_comb begin
        w_clr = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
                w_clr[wr_addr_i[w*AW +: AW]] = 1'b1;
            end
        end
    end

    // Later ports are applied last, so the highest-indexed port wins a collision.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
                    r_regs[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .clr_i      (w_clr),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .busy_o     (w_busy),
        .rsv_ok_o   (w_rsv_ok),
        .busy_cnt_o (busy_cnt_o)
    );

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            w_ra[p] = rd_addr_i[p*AW +: AW];
            w_rd[p] = (w_ra[p] == '0) ? '0 : r_regs[w_ra[p]];
            w_rb[p] = w_busy[w_ra[p]];
`ifdef REG_FILE_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_i[w] && (w_ra[p] != '0) && (wr_addr_i[w*AW +: AW] == w_ra[p])) begin
                    w_rd[p] = wr_data_i[w*XLEN +: XLEN];
                    w_rb[p] = w_rsv_ok && (rsv_addr_i == w_ra[p]);
                end
            end
`endif
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data_o[p*XLEN +: XLEN] = w_rd[p];
        end
    end

    assign rd_busy_o = w_rb;
    assign rsv_ok_o  = w_rsv_ok;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector bench for reg_file_sb; expectations adapt to REG_FILE_BYPASS_EN.
module tb_reg_file_sb;

    import custom_pkg::*;

    localparam int NRD = 2;
    localparam int NWR = 2;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk;
    logic                 rstn;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 rsv_en;
    reg_addr_t            rsv_addr;
    logic                 rsv_ok;
    logic [AW:0]          busy_cnt;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .rsv_ok_o   (rsv_ok),
        .busy_cnt_o (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wen;
        reg_addr_t   wa0;
        xlen_t       wd0;
        reg_addr_t   wa1;
        xlen_t       wd1;
        logic        ren;
        reg_addr_t   ra;
        reg_addr_t   ra0;
        reg_addr_t   ra1;
        xlen_t       ed0;
        logic        eb0;
        xlen_t       ed1;
        logic        eb1;
        logic        eok;
        logic [AW:0] ecnt;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];
    int   n_vec;
    int   n_cmp;
    int   n_err;

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, id, act, exp);
        end
    endtask

    task automatic drive_idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic apply(input vec_t v);
        wr_en    = v.wen;
        wr_addr  = {v.wa1, v.wa0};
        wr_data  = {v.wd1, v.wd0};
        rsv_en   = v.ren;
        rsv_addr = v.ra;
        rd_addr  = {v.ra1, v.ra0};
    endtask

    initial begin
        n_vec = 0;
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        rd_addr = '0;
        drive_idle();

        //          wen    wa0    wd0             wa1    wd1        ren  ra     ra0    ra1    ed0                           eb0   ed1            eb1   eok   ecnt
        tbl[0]  = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b0, 5'd0, 5'd0,  5'd5,  32'h0,                        1'b0, 32'h0,         1'b0, 1'b0, 6'd0};
        tbl[1]  = '{2'b01, 5'd0,  32'h1234,       5'd0,  32'h0,     1'b1, 5'd0, 5'd0,  5'd0,  32'h0,                        1'b0, 32'h0,         1'b0, 1'b1, 6'd0};
        tbl[2]  = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b0, 5'd0, 5'd0,  5'd1,  32'h0,                        1'b0, 32'h0,         1'b0, 1'b0, 6'd0};
        tbl[3]  = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b1, 5'd7, 5'd7,  5'd0,  32'h0,                        1'b0, 32'h0,         1'b0, 1'b1, 6'd0};
        tbl[4]  = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b1, 5'd7, 5'd7,  5'd0,  32'h0,                        1'b1, 32'h0,         1'b0, 1'b0, 6'd1};
        tbl[5]  = '{2'b01, 5'd7,  32'hA5,         5'd0,  32'h0,     1'b0, 5'd0, 5'd7,  5'd7,  BYP ? 32'hA5 : 32'h0,         !BYP, BYP ? 32'hA5 : 32'h0, !BYP, 1'b0, 6'd1};
        tbl[6]  = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b0, 5'd0, 5'd7,  5'd0,  32'hA5,                       1'b0, 32'h0,         1'b0, 1'b0, 6'd0};
        tbl[7]  = '{2'b11, 5'd3,  32'h11,         5'd3,  32'h22,    1'b0, 5'd0, 5'd7,  5'd0,  32'hA5,                       1'b0, 32'h0,         1'b0, 1'b0, 6'd0};
        tbl[8]  = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b0, 5'd0, 5'd3,  5'd7,  32'h22,                       1'b0, 32'hA5,        1'b0, 1'b0, 6'd0};
        tbl[9]  = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b1, 5'd9, 5'd9,  5'd3,  32'h0,                        1'b0, 32'h22,        1'b0, 1'b1, 6'd0};
        tbl[10] = '{2'b10, 5'd0,  32'h0,          5'd9,  32'h55,    1'b1, 5'd9, 5'd9,  5'd3,  BYP ? 32'h55 : 32'h0,         1'b1, 32'h22,        1'b0, 1'b1, 6'd1};
        tbl[11] = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b0, 5'd0, 5'd9,  5'd3,  32'h55,                       1'b1, 32'h22,        1'b0, 1'b0, 6'd1};
        tbl[12] = '{2'b01, 5'd4,  32'hCAFE,       5'd0,  32'h0,     1'b0, 5'd0, 5'd4,  5'd9,  BYP ? 32'hCAFE : 32'h0,       1'b0, 32'h55,        1'b1, 1'b0, 6'd1};
        tbl[13] = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b0, 5'd0, 5'd4,  5'd9,  32'hCAFE,                     1'b0, 32'h55,        1'b1, 1'b0, 6'd1};
        tbl[14] = '{2'b10, 5'd0,  32'h0,          5'd9,  32'h66,    1'b1, 5'd4, 5'd9,  5'd4,  BYP ? 32'h66 : 32'h55,        !BYP, 32'hCAFE,      1'b0, 1'b1, 6'd1};
        tbl[15] = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b0, 5'd0, 5'd9,  5'd4,  32'h66,                       1'b0, 32'hCAFE,      1'b1, 1'b0, 6'd1};
        tbl[16] = '{2'b01, 5'd5,  32'hDEADBEEF,   5'd0,  32'h0,     1'b0, 5'd0, 5'd5,  5'd4,  BYP ? 32'hDEADBEEF : 32'h0,   1'b0, 32'hCAFE,      1'b1, 1'b0, 6'd1};
        tbl[17] = '{2'b00, 5'd0,  32'h0,          5'd0,  32'h0,     1'b0, 5'd0, 5'd5,  5'd4,  32'hDEADBEEF,                 1'b0, 32'hCAFE,      1'b1, 1'b0, 6'd1};

        // Held in reset across edges: everything reads zero.
        rd_addr = {5'd5, 5'd7};
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        chk("rst_data", 0, 64'(rd_data), 64'h0);
        chk("rst_busy", 0, 64'(rd_busy), 64'h0);
        chk("rst_cnt",  0, 64'(busy_cnt), 64'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #2;
            n_vec++;
            chk("rd0_data", i, 64'(rd_data[XLEN-1:0]),      64'(tbl[i].ed0));
            chk("rd0_busy", i, 64'(rd_busy[0]),             64'(tbl[i].eb0));
            chk("rd1_data", i, 64'(rd_data[2*XLEN-1:XLEN]), 64'(tbl[i].ed1));
            chk("rd1_busy", i, 64'(rd_busy[1]),             64'(tbl[i].eb1));
            chk("rsv_ok",   i, 64'(rsv_ok),                 64'(tbl[i].eok));
            chk("busy_cnt", i, 64'(busy_cnt),               64'(tbl[i].ecnt));
        end

        // Asynchronous reset mid-cycle, with a write pending while reset is held.
        @(negedge clk);
        drive_idle();
        rd_addr = {5'd4, 5'd5};
        #1;
        n_vec++;
        chk("pre_rst_x5", 0, 64'(rd_data[XLEN-1:0]), 64'hDEADBEEF);
        rstn = 1'b0;
        #1;
        n_vec++;
        chk("arst_x5_data", 0, 64'(rd_data[XLEN-1:0]), 64'h0);
        chk("arst_x4_busy", 0, 64'(rd_busy[1]),        64'h0);
        chk("arst_cnt",     0, 64'(busy_cnt),          64'h0);
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd6};
        wr_data = {32'h0, 32'h77};
        rsv_en  = 1'b1;
        rsv_addr = 5'd6;
        @(negedge clk);
        drive_idle();
        rstn    = 1'b1;
        rd_addr = {5'd4, 5'd6};
        #2;
        n_vec++;
        chk("post_rst_x6",   0, 64'(rd_data[XLEN-1:0]), 64'h0);
        chk("post_rst_busy", 0, 64'(rd_busy),           64'h0);
        chk("post_rst_cnt",  0, 64'(busy_cnt),          64'h0);

        // Fill the scoreboard: every nonzero register reserved once.
        for (int a = 1; a < NREGS; a++) begin
            @(negedge clk);
            rsv_en   = 1'b1;
            rsv_addr = reg_addr_t'(a);
            #2;
            n_vec++;
            chk("fill_ok", a, 64'(rsv_ok), 64'h1);
        end
        @(negedge clk);
        rsv_en   = 1'b1;
        rsv_addr = 5'd1;
        rd_addr  = {5'd0, 5'd31};
        #2;
        n_vec++;
        chk("full_cnt",    0, 64'(busy_cnt),   64'(NREGS - 1));
        chk("full_rsv_ok", 0, 64'(rsv_ok),     64'h0);
        chk("full_busy31", 0, 64'(rd_busy[0]), 64'h1);
        chk("full_busy0",  0, 64'(rd_busy[1]), 64'h0);

        // Drain two registers per cycle; the final pair's second address wraps to x0.
        for (int a = 1; a < NREGS; a += 2) begin
            @(negedge clk);
            rsv_en  = 1'b0;
            wr_en   = 2'b11;
            wr_addr = {reg_addr_t'(a + 1), reg_addr_t'(a)};
            wr_data = {xlen_t'(a), xlen_t'(a)};
        end
        @(negedge clk);
        drive_idle();
        rd_addr = {5'd0, 5'd31};
        #2;
        n_vec++;
        chk("drain_cnt", 0, 64'(busy_cnt),                64'h0);
        chk("drain_x31", 0, 64'(rd_data[XLEN-1:0]),      64'd31);
        chk("drain_x0",  0, 64'(rd_data[2*XLEN-1:XLEN]), 64'h0);
        chk("drain_busy", 0, 64'(rd_busy),               64'h0);
        rd_addr = {5'd30, 5'd29};
        #1;
        chk("drain_x29", 0, 64'(rd_data[XLEN-1:0]),      64'd29);
        chk("drain_x30", 0, 64'(rd_data[2*XLEN-1:XLEN]), 64'd29);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-port integer register file with an integrated per-register busy scoreboard.
- Successor to the single-write, dual-read register file.
- Serves the decode/writeback stages of the multi-cycle core and the planned dual-issue variant.
- Decode reserves a destination register (busy set); writeback writes data and releases it (busy cleared).
- Read ports report value and busy status so decode can stall on RAW hazards.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of 2, >=2); AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- NWR, 2, number of write (writeback) ports.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rstn_i  in  1  reset. Asynchronous, active-low.
- rd_addr_i  in  NRD*AW  read addresses, port p at bits [p*AW +: AW].
- rd_data_o  out  NRD*XLEN  read data per port, combinational.
- rd_busy_o  out  NRD  busy bit of each addressed register, combinational.
- wr_en_i  in  NWR  write enable per write port.
- wr_addr_i  in  NWR*AW  write address per port.
- wr_data_i  in  NWR*XLEN  write data per port.
- rsv_en_i  in  1  reservation request (mark destination busy).
- rsv_addr_i  in  AW  register to reserve.
- rsv_ok_o  out  1  reservation accepted this cycle, combinational.
- busy_cnt_o  out  AW+1  number of currently busy registers (registered).

Behaviour:
- Reset (rstn_i low, async): all registers = 0, all busy bits = 0, busy_cnt_o = 0. Outputs follow immediately: rd_data_o = 0, rd_busy_o = 0.
- Register 0 is hardwired:
  - Writes to address 0 are ignored.
  - It is never busy.
  - It always reads 0.
  - A reservation of address 0 gives rsv_ok_o = 1 with no state change.
- Write: on the rising edge, for each port with wr_en_i[w]=1 and address != 0, the register takes wr_data_i[w].
  - Same-address collision between ports: the highest-indexed port wins.
  - Every enabled write to a nonzero address clears that register's busy bit.
- Reservation: rsv_ok_o = rsv_en_i & (addr==0 | !busy[addr] | write-clear of addr this cycle).
  - If rsv_ok_o=1 and addr!=0, the busy bit is set at the edge.
  - If rsv_en_i=1 and the register is busy with no clear this cycle: rsv_ok_o=0, no state change. The requester retries; there is no queueing.
- Simultaneous clear and set of the same register in one cycle: set wins. The new producer owns it and the busy bit stays 1.
- Read: rd_data_o / rd_busy_o are combinational from the stored state. Latency 0 for stored values; see the optional feature for same-cycle writes.
- busy_cnt_o:
  - Updates on the edge by (+1 if a set occurred) - (number of distinct registers actually cleared, excluding one re-set by the same cycle's reservation).
  - Always equals the popcount of the busy vector; never wraps, maximum NREGS-1.
- Out-of-range addresses are impossible (NREGS is a power of 2).
- Reset asserted mid-operation discards all pending writes and reservations.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined:
  - A read port whose address matches an enabled same-cycle write (nonzero address) returns that write's wr_data_i; the highest-indexed matching port wins.
  - rd_busy_o for that port reads 0 unless the same cycle's reservation re-sets it.
- Undefined: reads return the stored value; new data is visible the cycle after the edge, and busy clears after the edge.

Decomposition:
- Shared package (custom_pkg):
  - XLEN, NREGS and AW constants.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef xlen_t (logic [XLEN-1:0]).
- Sub-module reg_scoreboard:
  - Holds the busy vector, rsv_ok logic and busy_cnt counter.
  - Inputs: write-clear vector and reservation.
- The data array and read muxing stay in reg_file_sb.

Test Plan:
- Reset: assert rstn_i mid-run after writing x5=0xDEADBEEF -> rd_data_o=0 and rd_busy_o=0 immediately, without a clock edge; busy_cnt_o=0.
- x0: write 0x1234 to x0 and reserve x0 -> read x0=0, rsv_ok_o=1, busy_cnt_o remains 0.
- Scoreboard:
  - Reserve x7 -> next cycle rd_busy_o(x7)=1, busy_cnt_o=1.
  - Re-reserve x7 -> rsv_ok_o=0.
  - Write x7=0xA5 -> busy clears, busy_cnt_o=0, read 0xA5.
- Collision: port0 writes x3=0x11, port1 writes x3=0x22 in the same cycle -> x3=0x22 afterwards.
- Clear+set: x9 busy; write x9=0x55 and reserve x9 in the same cycle -> rsv_ok_o=1, x9 stays busy, value 0x55, busy_cnt_o unchanged.
- Bypass:
  - Write x4=0xCAFE while reading x4 in the same cycle.
  - With REG_FILE_BYPASS_EN: rd_data_o=0xCAFE in that cycle.
  - Without REG_FILE_BYPASS_EN: old value in that cycle, 0xCAFE the next cycle.
